seq_signed_divider: RTL and testbench
=====================================

// Module: seq_signed_divider
// PURPOSE
//  Multi-cycle signed divider, the inverse of the Booth multiplier datapath.
//  Divides a 2*SIZE-bit signed dividend (e.g. a MAC product) by a SIZE-bit signed divisor.
//  Returns a SIZE-bit quotient and remainder, truncating toward zero.
//  Used for normalisation/averaging stages of the CNN pipeline; one division in flight at a time.
// PARAMETERS
//  SIZE  16  operand width; dividend is 2*SIZE bits, quotient/remainder SIZE bits
// PORTS
//  clk          in   1        rising-edge clock (single clock domain)
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request; sampled only in IDLE
//  dividend     in   2*SIZE   signed dividend, captured on accepted start
//  divisor      in   SIZE     signed divisor, captured on accepted start
//  busy         out  1        high from accept edge until done edge
//  done         out  1        one-cycle pulse: results valid
//  quotient     out  SIZE     signed quotient, held until next done
//  remainder    out  SIZE     signed remainder, held until next done
//  div_by_zero  out  1        divisor was 0 (valid with done, held)
//  overflow     out  1        quotient did not fit SIZE bits (valid with done, held)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, quotient, remainder, div_by_zero, overflow all 0.
//    Reset mid-operation aborts immediately; no done is produced.
//  - FSM: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: start=1 at edge E0 captures |dividend|, |divisor|, signs; busy=1.
//      Divisor !=0 -> CALC. Divisor ==0 -> FIX directly.
//    CALC: unsigned restoring division, one quotient bit per cycle, MSB first.
//      Iterates 2*SIZE times with a (SIZE+1)-bit partial remainder. Then -> FIX.
//    FIX: apply signs, check overflow, write outputs. done=1, busy=0 for one cycle. -> IDLE.
//  - Latency: done is high in the cycle after edge E0+2*SIZE+1 (33 edges for SIZE=16).
//    Divide-by-zero: done after edge E0+2.
//  - start while busy is ignored and not queued.
//    start in the same cycle as done is ignored; it is accepted the cycle after.
//  - Sign rules: q sign = sign(dividend) XOR sign(divisor); r sign = sign(dividend).
//    |r| < |divisor| always.
//  - Overflow: set when q_mag > 2^(SIZE-1)-1 (positive q) or q_mag > 2^(SIZE-1) (negative q).
//    On overflow: quotient saturates to 0x7FF..F or 0x800..0, remainder = 0.
//  - Divide-by-zero: div_by_zero=1, overflow=0.
//    quotient = 0x7FF..F if dividend >= 0, else 0x800..0; remainder = dividend[SIZE-1:0].
//  - Most negative dividend (-2^(2*SIZE-1)): magnitude is handled as an unsigned 2*SIZE-bit value.
//  - Flags and results update only in FIX; they are stable at all other times.
// CONFIGURATION
//  DIV_ROUND_EN defined: FIX rounds the quotient to nearest, ties away from zero.
//    If 2*r_mag >= d_mag: q_mag += 1 and r_mag' = d_mag - r_mag.
//    The remainder then takes the sign opposite to the dividend.
//    Overflow is checked after rounding. Latency is unchanged.
//  DIV_ROUND_EN undefined: truncation toward zero, as above.
// TESTING (SIZE=16)
//  1. start, 100/7 -> after 33 edges done=1, q=14, r=2, flags 0; busy high exactly 33 cycles.
//  2. -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
//  3. 65536/1 -> overflow=1, q=0x7FFF, r=0.
//     -32768/1 -> q=0x8000, overflow=0.
//     -2^31/-1 -> overflow=1, q=0x7FFF.
//  4. 1234/0 -> done after edge E0+2, div_by_zero=1, q=0x7FFF, r=1234.
//     -5/0 -> q=0x8000, r=-5.
//  5. start pulsed during CALC is ignored, and the original result arrives on schedule.
//     Then assert rst at CALC cycle 10: all outputs 0, no done. Next start 9/3 -> q=3, r=0.
//  6. DIV_ROUND_EN: 100/8 -> q=13, r=-4; 99/8 -> q=12, r=3.
//     Without the macro: 100/8 -> q=12, r=4.

Source files
------------

// File: rtl/seq_signed_divider_if.sv
// Request/result bundle for seq_signed_divider: operands and start in, results and status out.
// SIZE must match the divider instance it is attached to.
interface seq_signed_divider_if #(
  parameter int unsigned SIZE = 16
);
  logic                  start;
  logic [2*SIZE-1:0]     dividend;
  logic [SIZE-1:0]       divisor;
  logic                  busy;
  logic                  done;
  logic [SIZE-1:0]       quotient;
  logic [SIZE-1:0]       remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2*SIZE-bit dividend / SIZE-bit divisor, restoring, MSB first.
// Optional macro DIV_ROUND_EN: round quotient to nearest (ties away from zero) instead of truncating.
module seq_signed_divider #(
  parameter int unsigned SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_signed_divider_if.slave  bus_io
);

  localparam int unsigned DvdW = 2 * SIZE;
  localparam int unsigned CntW = $clog2(DvdW);
  localparam logic [DvdW-1:0] QLim   = DvdW'(1) << (SIZE - 1);
  localparam logic [SIZE-1:0] SatPos = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] SatNeg = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q;
  logic [DvdW-1:0]   dvd_q;      // dividend magnitude, becomes the quotient as bits shift in
  logic [SIZE-1:0]   rem_q;
  logic [SIZE-1:0]   dsr_q;
  logic              sgn_dvd_q;
  logic              sgn_dsr_q;
  logic              dbz_q;
  logic              hold_q;
  logic [CntW-1:0]   cnt_q;

  logic              busy_q;
  logic              done_q;
  logic [SIZE-1:0]   quot_q;
  logic [SIZE-1:0]   rem_out_q;
  logic              dbz_out_q;
  logic              ovf_q;

  logic [DvdW-1:0]   dvd_in_mag;
  logic [SIZE-1:0]   dsr_in_mag;
  logic [SIZE:0]     trial;
  logic              q_bit;
  logic [SIZE-1:0]   rem_step;

  logic [DvdW-1:0]   q_mag;
  logic [SIZE-1:0]   r_mag;
  logic              q_neg;
  logic              r_neg;
  logic              ovf_d;
  logic [SIZE-1:0]   quot_d;
  logic [SIZE-1:0]   rem_d;

  always_comb begin
    dvd_in_mag = bus_io.dividend[DvdW-1] ? -bus_io.dividend : bus_io.dividend;
    dsr_in_mag = bus_io.divisor[SIZE-1]  ? -bus_io.divisor  : bus_io.divisor;
  end

  // One restoring step on the (SIZE+1)-bit partial remainder.
  always_comb begin
    trial    = {rem_q, dvd_q[DvdW-1]};
    q_bit    = (trial >= {1'b0, dsr_q});
    rem_step = q_bit ? SIZE'(trial - {1'b0, dsr_q}) : trial[SIZE-1:0];
  end

  always_comb begin
    q_mag = dvd_q;
    r_mag = rem_q;
    q_neg = sgn_dvd_q ^ sgn_dsr_q;
    r_neg = sgn_dvd_q;
`ifdef DIV_ROUND_EN
    if ({r_mag, 1'b0} >= {1'b0, dsr_q}) begin
      q_mag = dvd_q + DvdW'(1);
      r_mag = dsr_q - rem_q;
      r_neg = ~sgn_dvd_q;
    end
`endif
    // A negative quotient may reach one step further than a positive one.
    ovf_d  = q_neg ? (q_mag > QLim) : (q_mag >= QLim);
    quot_d = q_neg ? -q_mag[SIZE-1:0] : q_mag[SIZE-1:0];
    rem_d  = r_neg ? -r_mag : r_mag;
    if (ovf_d) begin
      quot_d = q_neg ? SatNeg : SatPos;
      rem_d  = '0;
    end
    if (dbz_q) begin
      ovf_d  = 1'b0;
      quot_d = sgn_dvd_q ? SatNeg : SatPos;
      rem_d  = sgn_dvd_q ? -dvd_q[SIZE-1:0] : dvd_q[SIZE-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dsr_q <= 1'b0;
      dbz_q     <= 1'b0;
      hold_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (bus_io.start && !done_q) begin
            dvd_q     <= dvd_in_mag;
            dsr_q     <= dsr_in_mag;
            sgn_dvd_q <= bus_io.dividend[DvdW-1];
            sgn_dsr_q <= bus_io.divisor[SIZE-1];
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dbz_q     <= (bus_io.divisor == '0);
            hold_q    <= (bus_io.divisor == '0);
            state_q   <= (bus_io.divisor == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          rem_q <= rem_step;
          dvd_q <= {dvd_q[DvdW-2:0], q_bit};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DvdW - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // Divide-by-zero spends one extra cycle here so it completes two edges after accept.
          if (hold_q) begin
            hold_q <= 1'b0;
          end else begin
            quot_q    <= quot_d;
            rem_out_q <= rem_d;
            dbz_out_q <= dbz_q;
            ovf_q     <= ovf_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.quotient    = quot_q;
  assign bus_io.remainder   = rem_out_q;
  assign bus_io.div_by_zero = dbz_out_q;
  assign bus_io.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider (SIZE=16), truncating or rounding build.
module tb_seq_signed_divider;

  localparam int unsigned SIZE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seq_signed_divider_if #(.SIZE(SIZE)) dif ();

  seq_signed_divider #(.SIZE(SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (dif)
  );

  always #5 clk = ~clk;

  // Issues one division; returns edges from accept to done and the number of busy samples.
  task automatic do_div(input logic [31:0] a, input logic [15:0] b, input int pulse_at,
                        output int edges, output int busy_n);
    @(posedge clk); #1;
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    @(posedge clk); #1;
    dif.start    = 1'b0;
    dif.dividend = 32'hDEAD_BEEF;
    dif.divisor  = 16'h0001;
    edges  = 0;
    busy_n = (dif.busy === 1'b1) ? 1 : 0;
    while (edges < 100) begin
      @(posedge clk); #1;
      edges++;
      dif.start = (edges == pulse_at);
      if (dif.done === 1'b1) break;
      if (dif.busy === 1'b1) busy_n++;
    end
    dif.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    rst = 1'b1;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    got = {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
    total++;
    if (got !== 36'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", got, 36'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_truncate();
    logic [31:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] eq [4];
    logic [15:0] er [4];
    logic [34:0] got;
    logic [34:0] exp;
    int edges;
    int busy_n;
    va = '{32'd100, -32'sd100, 32'd100, -32'sd100};
    vb = '{16'd7, 16'd7, -16'sd7, -16'sd7};
    eq = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h000E};
    er = '{16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE};
    for (int i = 0; i < 4; i++) begin
      do_div(va[i], vb[i], -1, edges, busy_n);
      total++;
      if (edges !== 33) begin
        bad++;
        $display("FAIL trunc_latency[%0d]: got %0d edges expected 33", i, edges);
      end
      got = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow, dif.busy};
      exp = {eq[i], er[i], 3'b000};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL trunc_result[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 0) begin
        total++;
        if (busy_n !== 33) begin
          bad++;
          $display("FAIL busy_cycles: got %0d expected 33", busy_n);
        end
      end
    end
    @(posedge clk); #1;
    total++;
    if ({dif.done, dif.quotient, dif.remainder} !== {1'b0, 16'h000E, 16'hFFFE}) begin
      bad++;
      $display("FAIL result_hold: got %h expected %h",
               {dif.done, dif.quotient, dif.remainder}, {1'b0, 16'h000E, 16'hFFFE});
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va [3];
    logic [15:0] vb [3];
    logic [33:0] exp [3];
    logic [33:0] got;
    int edges;
    int busy_n;
    va  = '{32'd65536, -32'sd32768, 32'h8000_0000};
    vb  = '{16'd1, 16'd1, 16'hFFFF};
    exp = '{{16'h7FFF, 16'h0000, 2'b01}, {16'h8000, 16'h0000, 2'b00},
            {16'h7FFF, 16'h0000, 2'b01}};
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], -1, edges, busy_n);
      got = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
      total++;
      if (got !== exp[i] || edges !== 33) begin
        bad++;
        $display("FAIL overflow[%0d]: got %h after %0d edges expected %h after 33",
                 i, got, edges, exp[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] va [2];
    logic [33:0] exp [2];
    logic [33:0] got;
    int edges;
    int busy_n;
    va  = '{32'd1234, -32'sd5};
    exp = '{{16'h7FFF, 16'h04D2, 2'b10}, {16'h8000, 16'hFFFB, 2'b10}};
    for (int i = 0; i < 2; i++) begin
      do_div(va[i], 16'h0000, -1, edges, busy_n);
      total++;
      if (edges !== 2) begin
        bad++;
        $display("FAIL dbz_latency[%0d]: got %0d edges expected 2", i, edges);
      end
      got = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL dbz_result[%0d]: got %h expected %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_busy_and_abort();
    logic [35:0] got;
    int edges;
    int busy_n;
    int done_seen;
    do_div(32'd1000, 16'd3, 5, edges, busy_n);
    total++;
    if (edges !== 33 || {dif.quotient, dif.remainder} !== {16'h014D, 16'h0001}) begin
      bad++;
      $display("FAIL start_while_busy: got q=%h r=%h after %0d edges expected 014d 0001 after 33",
               dif.quotient, dif.remainder, edges);
    end
    @(posedge clk); #1;
    dif.dividend = 32'd1000;
    dif.divisor  = 16'd3;
    dif.start    = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    got = {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
    total++;
    if (got !== 36'h0) begin
      bad++;
      $display("FAIL abort_outputs: got %h expected %h", got, 36'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.done !== 1'b0 || dif.busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d active samples expected 0", done_seen);
    end
    do_div(32'd9, 16'd3, -1, edges, busy_n);
    total++;
    if (edges !== 33 || {dif.quotient, dif.remainder} !== {16'h0003, 16'h0000}) begin
      bad++;
      $display("FAIL after_abort: got q=%h r=%h after %0d edges expected 0003 0000 after 33",
               dif.quotient, dif.remainder, edges);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int edges;
    int busy_n;
`ifdef DIV_ROUND_EN
    exp_a = {16'h000D, 16'hFFFC};
`else
    exp_a = {16'h000C, 16'h0004};
`endif
    exp_b = {16'h000C, 16'h0003};
    do_div(32'd100, 16'd8, -1, edges, busy_n);
    total++;
    if ({dif.quotient, dif.remainder} !== exp_a || edges !== 33) begin
      bad++;
      $display("FAIL round_100_8: got %h after %0d edges expected %h after 33",
               {dif.quotient, dif.remainder}, edges, exp_a);
    end
    do_div(32'd99, 16'd8, -1, edges, busy_n);
    total++;
    if ({dif.quotient, dif.remainder} !== exp_b) begin
      bad++;
      $display("FAIL round_99_8: got %h expected %h", {dif.quotient, dif.remainder}, exp_b);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    logic [34:0] got1;
    logic [34:0] got2;
    logic [34:0] exp2;
`ifdef DIV_ROUND_EN
    exp2 = {16'h0004, 16'hFFFD, 3'b000};
`else
    exp2 = {16'h0003, 16'h0003, 3'b000};
`endif
    first = 0;
    second = 0;
    got1 = '0;
    got2 = '0;
    @(posedge clk); #1;
    dif.dividend = 32'd20;
    dif.divisor  = 16'd6;
    dif.start    = 1'b1;
    @(posedge clk); #1;
    dif.dividend = 32'd21;
    for (int e = 1; e <= 200 && second == 0; e++) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) begin
        if (first == 0) begin
          first = e;
          got1 = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow, dif.busy};
        end else begin
          second = e;
          got2 = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow, dif.busy};
        end
      end
    end
    dif.start = 1'b0;
    total++;
    if (first !== 33 || got1 !== {16'h0003, 16'h0002, 3'b000}) begin
      bad++;
      $display("FAIL b2b_first: got %h at edge %0d expected %h at 33",
               got1, first, {16'h0003, 16'h0002, 3'b000});
    end
    total++;
    if (second !== 68 || got2 !== exp2) begin
      bad++;
      $display("FAIL b2b_second: got %h at edge %0d expected %h at 68", got2, second, exp2);
    end
  endtask

  initial begin
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    test_reset();
    test_truncate();
    test_overflow();
    test_div_by_zero();
    test_busy_and_abort();
    test_rounding();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
